// File: rtl/ordenador_caminho.sv
// Path reorder buffer: captures predecessor-walk nodes (destination first) into a LIFO
// and replays them source first over a valid/ready stream, flagging overflow.
module ordenador_caminho #(
  parameter int ADDR_WIDTH = 10,
  parameter int PROF_MAX   = 64,
  parameter int CNT_W      = $clog2(PROF_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cancelar_in,
  input  logic                  caminho_valid_in,
  input  logic [ADDR_WIDTH-1:0] caminho_data_in,
  input  logic                  caminho_ultimo_in,
  output logic                  caminho_ready_out,
  output logic                  saida_valid_out,
  output logic [ADDR_WIDTH-1:0] saida_data_out,
  output logic                  saida_ultimo_out,
  input  logic                  saida_ready_in,
  output logic [CNT_W-1:0]      tamanho_out,
  output logic                  ocupado_out,
  output logic                  erro_out
);

  localparam int IDX_W = (PROF_MAX > 1) ? $clog2(PROF_MAX) : 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CAPTURA = 2'd1,
    ENVIO   = 2'd2
  } estado_t;

  estado_t                 state_q, state_d;
  logic [CNT_W-1:0]        ptr_q, ptr_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   data_q, data_d;
  logic                    ultimo_q, ultimo_d;
  logic [CNT_W-1:0]        tamanho_q, tamanho_d;
  logic                    ocupado_q, ocupado_d;
  logic                    erro_q, erro_d;

  logic [ADDR_WIDTH-1:0]   mem [PROF_MAX];
  logic                    wr_en_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic [CNT_W-1:0]        rd_ptr_s;
  logic                    xfer_s;
  logic                    cheio_s;

  assign xfer_s   = caminho_valid_in & ready_q;
  assign cheio_s  = (ptr_q == CNT_W'(PROF_MAX));
  // Next node to present after a pop: two below the current pointer
  assign rd_ptr_s = ptr_q - CNT_W'(2);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ultimo_d  = ultimo_q;
    tamanho_d = tamanho_q;
    erro_d    = erro_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = ptr_q[IDX_W-1:0];
    if (cancelar_in) begin
      state_d  = OCIOSO;
      ptr_d    = {CNT_W{1'b0}};
      valid_d  = 1'b0;
      ultimo_d = 1'b0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (xfer_s) begin
            erro_d    = 1'b0;
            wr_en_s   = 1'b1;
            wr_idx_s  = {IDX_W{1'b0}};
            ptr_d     = CNT_W'(1);
            tamanho_d = CNT_W'(1);
            if (caminho_ultimo_in) begin
              state_d  = ENVIO;
              valid_d  = 1'b1;
              data_d   = caminho_data_in;
              ultimo_d = 1'b1;
            end else begin
              state_d = CAPTURA;
            end
          end else begin
            state_d = OCIOSO;
          end
        end
        CAPTURA: begin
          if (xfer_s) begin
            if (cheio_s) begin
              erro_d = 1'b1;
            end else begin
              wr_en_s   = 1'b1;
              ptr_d     = ptr_q + CNT_W'(1);
              tamanho_d = ptr_q + CNT_W'(1);
            end
            // A path that lost any node is discarded rather than replayed
            if (caminho_ultimo_in) begin
              if (cheio_s || erro_q) begin
                state_d = OCIOSO;
                ptr_d   = {CNT_W{1'b0}};
              end else begin
                state_d  = ENVIO;
                valid_d  = 1'b1;
                data_d   = caminho_data_in;
                ultimo_d = (ptr_q == {CNT_W{1'b0}});
              end
            end else begin
              state_d = CAPTURA;
            end
          end else begin
            state_d = CAPTURA;
          end
        end
        ENVIO: begin
          if (saida_ready_in) begin
            if (ptr_q > CNT_W'(1)) begin
              ptr_d    = ptr_q - CNT_W'(1);
              data_d   = mem[rd_ptr_s[IDX_W-1:0]];
              ultimo_d = (ptr_q == CNT_W'(2));
            end else begin
              ptr_d    = {CNT_W{1'b0}};
              valid_d  = 1'b0;
              ultimo_d = 1'b0;
              state_d  = OCIOSO;
            end
          end else begin
            state_d = ENVIO;
          end
        end
        default: begin
          state_d  = OCIOSO;
          ptr_d    = {CNT_W{1'b0}};
          valid_d  = 1'b0;
          ultimo_d = 1'b0;
        end
      endcase
    end
    ready_d   = (state_d != ENVIO);
    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OCIOSO;
      ptr_q     <= {CNT_W{1'b0}};
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= {ADDR_WIDTH{1'b0}};
      ultimo_q  <= 1'b0;
      tamanho_q <= {CNT_W{1'b0}};
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ultimo_q  <= ultimo_d;
      tamanho_q <= tamanho_d;
      ocupado_q <= ocupado_d;
      erro_q    <= erro_d;
    end
  end

  // LIFO storage needs no reset: the pointer defines which entries are live
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= caminho_data_in;
    end
  end

  assign caminho_ready_out = ready_q;
  assign saida_valid_out   = valid_q;
  assign saida_data_out    = data_q;
  assign saida_ultimo_out  = ultimo_q;
  assign tamanho_out       = tamanho_q;
  assign ocupado_out       = ocupado_q;
  assign erro_out          = erro_q;

endmodule

// File: tb/tb_ordenador_caminho.sv
// Directed plus randomized bench for ordenador_caminho; a queue-based stack model
// supplies every expected output.
module tb_ordenador_caminho;

  localparam int AW = 10;
  localparam int PM = 4;
  localparam int CW = $clog2(PM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cancelar_in = 1'b0;
  logic          caminho_valid_in = 1'b0;
  logic [AW-1:0] caminho_data_in = '0;
  logic          caminho_ultimo_in = 1'b0;
  logic          caminho_ready_out;
  logic          saida_valid_out;
  logic [AW-1:0] saida_data_out;
  logic          saida_ultimo_out;
  logic          saida_ready_in = 1'b0;
  logic [CW-1:0] tamanho_out;
  logic          ocupado_out;
  logic          erro_out;

  int total = 0;
  int bad = 0;

  ordenador_caminho #(.ADDR_WIDTH(AW), .PROF_MAX(PM)) dut (
    .clk(clk), .rst(rst), .cancelar_in(cancelar_in),
    .caminho_valid_in(caminho_valid_in), .caminho_data_in(caminho_data_in),
    .caminho_ultimo_in(caminho_ultimo_in), .caminho_ready_out(caminho_ready_out),
    .saida_valid_out(saida_valid_out), .saida_data_out(saida_data_out),
    .saida_ultimo_out(saida_ultimo_out), .saida_ready_in(saida_ready_in),
    .tamanho_out(tamanho_out), .ocupado_out(ocupado_out), .erro_out(erro_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] erro_exp);
    chk({tag, "_valid"}, 32'(saida_valid_out), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado_out), 32'd0);
    chk({tag, "_ready"}, 32'(caminho_ready_out), 32'd1);
    chk({tag, "_erro"}, 32'(erro_out), erro_exp);
  endtask

  // mode: 0 = ready always high, 1 = ready toggling 1010.., 2 = random ready
  task automatic run_path(input int nodes[$], input int mode, input bit noise);
    int stack[$];
    int n;
    int budget;
    bit rdy;
    n = nodes.size();
    for (int i = 0; i < n; i++) begin
      chk("cap_ready", 32'(caminho_ready_out), 32'd1);
      caminho_valid_in  = 1'b1;
      caminho_data_in   = AW'(nodes[i]);
      caminho_ultimo_in = (i == n - 1);
      tick();
      if (i < n - 1) begin
        chk("cap_tamanho", 32'(tamanho_out), 32'((i + 1 < PM) ? i + 1 : PM));
        chk("cap_valid", 32'(saida_valid_out), 32'd0);
        chk("cap_ocupado", 32'(ocupado_out), 32'd1);
        chk("cap_erro", 32'(erro_out), 32'(i + 1 > PM));
      end
    end
    caminho_valid_in  = 1'b0;
    caminho_ultimo_in = 1'b0;
    if (n > PM) begin
      chk_idle("ovf", 32'd1);
      return;
    end
    chk("env_erro", 32'(erro_out), 32'd0);
    for (int i = 0; i < n; i++) stack.push_back(nodes[i]);
    budget = 0;
    while (stack.size() > 0 && budget < 60) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (budget % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      saida_ready_in = rdy;
      if (noise) begin
        caminho_valid_in = 1'($urandom_range(0, 1));
        caminho_data_in  = AW'($urandom_range(0, 1023));
      end
      chk("env_valid", 32'(saida_valid_out), 32'd1);
      chk("env_data", 32'(saida_data_out), 32'(stack[$]));
      chk("env_ultimo", 32'(saida_ultimo_out), 32'(stack.size() == 1));
      chk("env_tamanho", 32'(tamanho_out), 32'(n));
      chk("env_ready", 32'(caminho_ready_out), 32'd0);
      chk("env_ocupado", 32'(ocupado_out), 32'd1);
      tick();
      if (rdy) void'(stack.pop_back());
      budget++;
    end
    saida_ready_in   = 1'b0;
    caminho_valid_in = 1'b0;
    chk("drain_budget", 32'(stack.size()), 32'd0);
    chk_idle("done", 32'd0);
  endtask

  initial begin
    int q[$];
    int n;
    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk_idle("rst", 32'd0);
    chk("rst_data", 32'(saida_data_out), 32'd0);
    chk("rst_ultimo", 32'(saida_ultimo_out), 32'd0);
    chk("rst_tamanho", 32'(tamanho_out), 32'd0);

    // 5,7,2 with ready always high, then with toggling ready
    q = '{5, 7, 2};
    run_path(q, 0, 1'b0);
    run_path(q, 1, 1'b0);

    // single-node path
    q = '{9};
    run_path(q, 0, 1'b0);

    // overflow: six nodes into a depth-4 LIFO, then a clean path
    q = '{11, 12, 13, 14, 15, 16};
    run_path(q, 0, 1'b0);
    q = '{3, 1};
    run_path(q, 0, 1'b0);

    // cancel during replay after the first accept
    q = '{5, 7, 2};
    for (int i = 0; i < 3; i++) begin
      caminho_valid_in  = 1'b1;
      caminho_data_in   = AW'(q[i]);
      caminho_ultimo_in = (i == 2);
      tick();
    end
    caminho_valid_in  = 1'b0;
    caminho_ultimo_in = 1'b0;
    saida_ready_in    = 1'b1;
    chk("cnc_first", 32'(saida_data_out), 32'd2);
    tick();
    saida_ready_in = 1'b0;
    chk("cnc_second", 32'(saida_data_out), 32'd7);
    cancelar_in = 1'b1;
    tick();
    cancelar_in = 1'b0;
    chk("cnc_valid", 32'(saida_valid_out), 32'd0);
    chk("cnc_ready", 32'(caminho_ready_out), 32'd1);
    chk("cnc_ocupado", 32'(ocupado_out), 32'd0);
    q = '{4};
    run_path(q, 0, 1'b0);

    // reset in the middle of capture
    for (int i = 0; i < 2; i++) begin
      caminho_valid_in = 1'b1;
      caminho_data_in  = AW'(20 + i);
      tick();
    end
    caminho_valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mrst", 32'd0);
    chk("mrst_data", 32'(saida_data_out), 32'd0);
    chk("mrst_ultimo", 32'(saida_ultimo_out), 32'd0);
    chk("mrst_tamanho", 32'(tamanho_out), 32'd0);
    q = '{8};
    run_path(q, 0, 1'b0);

    // randomized paths, including overflowing lengths and input noise during replay
    for (int k = 0; k < 30; k++) begin
      q.delete();
      n = $urandom_range(1, PM + 2);
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 1023));
      run_path(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
